// File: rtl/if_fetch_queue_pkg.sv
`default_nettype none
// ============================================================================
// Module      : if_fetch_queue_pkg
// Description : Shared widths, reset address and queue entry layout for the
//               instruction-fetch stage.
// Revision    : 1.0 - initial release
// ============================================================================
package if_fetch_queue_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h1c00_0000;
    localparam int          INST_W           = 32;
    localparam int          IF_TO_ID_W       = 64;

    typedef struct packed {
        logic [31:0]       pc;
        logic [INST_W-1:0] inst;
    } if_entry_t;

endpackage
`default_nettype wire

// File: rtl/if_fetch_queue_if.sv
`default_nettype none
// ============================================================================
// Module      : if_fetch_queue_if
// Description : Redirect, ID handshake and instruction SRAM signals of the
//               fetch stage.
// Revision    : 1.0 - initial release
// ============================================================================
interface if_fetch_queue_if
    import if_fetch_queue_pkg::*;
#(
    parameter int QDEPTH = 4
);
    localparam int CNT_W = $clog2(QDEPTH + 1);

    logic                  br_valid;
    logic [31:0]           br_target;
    logic                  id_allowin;
    logic                  if_validout;
    logic [IF_TO_ID_W-1:0] if_to_id_bus;
    logic [CNT_W-1:0]      q_count;
    logic                  inst_sram_en;
    logic [3:0]            inst_sram_we;
    logic [31:0]           inst_sram_addr;
    logic [31:0]           inst_sram_wdata;
    logic [INST_W-1:0]     inst_sram_rdata;

    modport slave (
        input  br_valid, br_target, id_allowin, inst_sram_rdata,
        output if_validout, if_to_id_bus, q_count,
               inst_sram_en, inst_sram_we, inst_sram_addr, inst_sram_wdata
    );

    modport master (
        output br_valid, br_target, id_allowin, inst_sram_rdata,
        input  if_validout, if_to_id_bus, q_count,
               inst_sram_en, inst_sram_we, inst_sram_addr, inst_sram_wdata
    );

endinterface
`default_nettype wire

// File: rtl/if_fetch_queue_fetch_fifo.sv
`default_nettype none
// ============================================================================
// Module      : fetch_fifo
// Description : Synchronous FIFO with flush; flush dominates push and pop.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_fifo #(
    parameter  int WIDTH = 64,
    parameter  int DEPTH = 4,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             i_flush,
    input  wire logic             i_push,
    input  wire logic [WIDTH-1:0] i_wdata,
    input  wire logic             i_pop,
    output logic      [WIDTH-1:0] o_rdata,
    output logic      [CNT_W-1:0] o_count
);
    localparam logic [CNT_W-1:0] c_depth = CNT_W'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [CNT_W-1:0] r_count;
    logic             w_push;
    logic             w_pop;

    assign w_push  = i_push & ~i_flush & (r_count != c_depth);
    assign w_pop   = i_pop  & ~i_flush & (r_count != '0);
    assign o_rdata = r_mem[r_rptr];
    assign o_count = r_count;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= i_wdata;
        end
    end

    // Power-of-two depth lets the pointers wrap on overflow
    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/if_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : if_fetch_queue
// Description : Sequential instruction fetch with credit-limited issue, a
//               decoupling queue toward ID, and same-cycle branch redirect.
// Revision    : 1.0 - initial release
// ============================================================================
module if_fetch_queue
    import if_fetch_queue_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int          QDEPTH   = 4
) (
    input  wire logic       clk,
    input  wire logic       rst,
    if_fetch_queue_if.slave bus
);
    localparam int                 CNT_W    = $clog2(QDEPTH + 1);
    localparam logic [CNT_W:0]     c_qdepth = (CNT_W + 1)'(QDEPTH);

    logic [31:0]      r_fpc;
    logic             r_pend;
    logic [31:0]      r_pend_pc;
    logic [CNT_W-1:0] w_occ;
    logic [CNT_W:0]   w_inflight;
    logic             w_issue;
    logic [31:0]      w_addr;
    logic             w_pop;
    if_entry_t        w_push_entry;
    if_entry_t        w_head;
    logic             w_unused_tgt;

    assign w_unused_tgt = &{1'b0, bus.br_target[1:0]};

    // Queued entries plus the one in flight must never exceed the queue size
    assign w_inflight = {1'b0, w_occ} + {{CNT_W{1'b0}}, r_pend};
    assign w_issue    = ~rst & (bus.br_valid | (w_inflight < c_qdepth));
    assign w_addr     = bus.br_valid ? {bus.br_target[31:2], 2'b00} : r_fpc;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fpc     <= RESET_PC;
            r_pend    <= 1'b0;
            r_pend_pc <= '0;
        end else if (w_issue) begin
            r_fpc     <= w_addr + 32'd4;
            r_pend    <= 1'b1;
            r_pend_pc <= w_addr;
        end else begin
            r_pend    <= 1'b0;
        end
    end

    // A redirect flushes the queue, which also discards this cycle's response
    assign w_push_entry = '{pc: r_pend_pc, inst: bus.inst_sram_rdata};
    assign w_pop        = bus.if_validout & bus.id_allowin;

    fetch_fifo #(
        .WIDTH (IF_TO_ID_W),
        .DEPTH (QDEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_flush (bus.br_valid),
        .i_push  (r_pend),
        .i_wdata (w_push_entry),
        .i_pop   (w_pop),
        .o_rdata (w_head),
        .o_count (w_occ)
    );

    assign bus.if_validout     = (w_occ != '0) & ~bus.br_valid;
    assign bus.if_to_id_bus    = w_head;
    assign bus.q_count         = w_occ;
    assign bus.inst_sram_en    = w_issue;
    assign bus.inst_sram_we    = 4'h0;
    assign bus.inst_sram_addr  = w_addr;
    assign bus.inst_sram_wdata = 32'h0;

endmodule
`default_nettype wire
